// File: rtl/aq_djpeg_mcu_sched.sv
// MCU-order block scheduler for the Huffman decoder: walks Y sub-blocks then Cb/Cr per MCU,
// tracks the restart interval and flags end of image.
module aq_djpeg_mcu_sched #(
   parameter int unsigned CW = 12,
   parameter int unsigned RW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ProcessInit,
   input  logic          Start,
   input  logic [2:0]    JpegComp,
   input  logic [1:0]    SubSamplingW,
   input  logic [1:0]    SubSamplingH,
   input  logic [CW-1:0] McuWidth,
   input  logic [CW-1:0] McuHeight,
   input  logic [RW-1:0] RestartInterval,
   input  logic          NextBlock,
   input  logic          RestartAck,
   output logic [2:0]    BlockColor,
   output logic [CW-1:0] BlockX,
   output logic [CW-1:0] BlockY,
   output logic          LastInMcu,
   output logic          Busy,
   output logic          RestartReq,
   output logic          DcReset,
   output logic          Finish
);

   typedef enum logic [1:0] {StIdle, StRun, StRstWait, StDone} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] mcu_x_q, mcu_x_d, mcu_y_q, mcu_y_d;
   logic [2:0]    sub_q, sub_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic          dc_reset_d;

   logic          grey, sw2, sh2;
   logic [2:0]    ny, last_sub;
   logic [1:0]    yidx;
   logic [2:0]    color_d;
   logic [CW-1:0] blk_x_d, blk_y_d;
   logic          last_d;

   // Greyscale scans always use one Y block per MCU regardless of the sampling inputs.
   assign grey     = (JpegComp == 3'd1);
   assign sw2      = !grey && (SubSamplingW >= 2'd2);
   assign sh2      = !grey && (SubSamplingH >= 2'd2);
   assign ny       = (sw2 && sh2) ? 3'd4 : ((sw2 || sh2) ? 3'd2 : 3'd1);
   assign last_sub = grey ? (ny - 3'd1) : (ny + 3'd1);

   always_comb begin
      state_d    = state_q;
      mcu_x_d    = mcu_x_q;
      mcu_y_d    = mcu_y_q;
      sub_d      = sub_q;
      rst_cnt_d  = rst_cnt_q;
      dc_reset_d = 1'b0;
      if (ProcessInit) begin
         state_d   = StIdle;
         mcu_x_d   = '0;
         mcu_y_d   = '0;
         sub_d     = '0;
         rst_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Start) begin
                  state_d    = StRun;
                  dc_reset_d = 1'b1;
                  mcu_x_d    = '0;
                  mcu_y_d    = '0;
                  sub_d      = '0;
                  rst_cnt_d  = '0;
               end
            end
            StRun: begin
               if (NextBlock) begin
                  if (sub_q != last_sub) begin
                     sub_d = sub_q + 3'd1;
                  end else if (mcu_x_q == McuWidth - CW'(1) &&
                               mcu_y_q == McuHeight - CW'(1)) begin
                     state_d = StDone;
                  end else begin
                     sub_d = '0;
                     if (mcu_x_q == McuWidth - CW'(1)) begin
                        mcu_x_d = '0;
                        mcu_y_d = mcu_y_q + CW'(1);
                     end else begin
                        mcu_x_d = mcu_x_q + CW'(1);
                     end
                     if (RestartInterval != '0 &&
                         rst_cnt_q == RestartInterval - RW'(1)) begin
                        state_d   = StRstWait;
                        rst_cnt_d = '0;
                     end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                     end
                  end
               end
            end
            StRstWait: begin
               if (RestartAck) begin
                  state_d    = StRun;
                  dc_reset_d = 1'b1;
               end
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   // Block tag and coordinates for the block selected by the next-state counters.
   always_comb begin
      yidx    = sub_d[1:0];
      color_d = sub_d;
      blk_x_d = mcu_x_d;
      blk_y_d = mcu_y_d;
      if (sub_d < ny) begin
         if (sw2) begin
            blk_x_d = {mcu_x_d[CW-2:0], yidx[0]};
            blk_y_d = sh2 ? {mcu_y_d[CW-2:0], yidx[1]} : mcu_y_d;
         end else if (sh2) begin
            blk_y_d = {mcu_y_d[CW-2:0], yidx[0]};
         end
      end else begin
         color_d = sub_d - ny + 3'd4;
      end
      last_d = (sub_d == last_sub);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         mcu_x_q    <= '0;
         mcu_y_q    <= '0;
         sub_q      <= '0;
         rst_cnt_q  <= '0;
         BlockColor <= '0;
         BlockX     <= '0;
         BlockY     <= '0;
         LastInMcu  <= 1'b0;
         Busy       <= 1'b0;
         RestartReq <= 1'b0;
         DcReset    <= 1'b0;
         Finish     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcu_x_q    <= mcu_x_d;
         mcu_y_q    <= mcu_y_d;
         sub_q      <= sub_d;
         rst_cnt_q  <= rst_cnt_d;
         Busy       <= (state_d == StRun) || (state_d == StRstWait);
         RestartReq <= (state_d == StRstWait);
         DcReset    <= dc_reset_d;
         Finish     <= (state_d == StDone);
         if (state_d == StIdle) begin
            BlockColor <= '0;
            BlockX     <= '0;
            BlockY     <= '0;
            LastInMcu  <= 1'b0;
         end else if (state_d != StDone) begin
            BlockColor <= color_d;
            BlockX     <= blk_x_d;
            BlockY     <= blk_y_d;
            LastInMcu  <= last_d;
         end
      end
   end

endmodule
